exc_commit: RTL and testbench
=============================

Name: exc_commit

Overview:
- Exception commit unit at the MEM stage of the pipeline; acts as initiator for the CP0 exception interface.
- Gathers per-instruction exception flags from the pipeline and the CP0 interrupt-response line, then prioritises them.
- Produces the one-cycle CP0 exception/eret pulse, a pipeline flush window and a PC redirect to the exception vector or EPC.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush stays high after a commit (1..7).
- VEC_BEV1, 32'hBFC00380, exception vector when Status.BEV=1.
- VEC_BEV0, 32'h80000180, exception vector when Status.BEV=0.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- mem_valid  in  1  instruction present in MEM
- mem_ready  in  1  MEM instruction completes this cycle
- mem_pc  in  32  PC of MEM instruction
- mem_bd  in  1  MEM instruction is in a branch delay slot
- mem_adel_if  in  1  fetch address error
- mem_ri  in  1  reserved instruction
- mem_ov  in  1  arithmetic overflow
- mem_sys  in  1  syscall
- mem_bp  in  1  break
- mem_adel  in  1  load address error
- mem_ades  in  1  store address error
- mem_eret  in  1  eret instruction
- mem_daddr  in  32  data virtual address
- int_response  in  1  CP0 unmasked interrupt request
- cp0_epc  in  32  current CP0 EPC
- status_bev  in  1  CP0 Status.BEV
- exc_valid  out  1  CP0 exception/eret strobe
- exc_excode  out  5  CP0 exception code
- exc_bd  out  1  CP0 branch-delay flag
- exc_epc  out  32  CP0 EPC value
- exc_badvaddr  out  32  CP0 BadVAddr value
- exc_eret  out  1  CP0 eret flag
- flush  out  1  kill IF..MEM instructions
- redirect_valid  out  1  PC redirect strobe
- redirect_pc  out  32  redirect target

Behaviour:
- Reset (async, resetn=0): FSM→IDLE, int_pend=0, flush_cnt=0, flush=0, redirect_valid=0, redirect_pc=0.
- Reset value of exc_* outputs: combinational, so 0 while in IDLE with no commit.
- FSM states:
  - IDLE: commit = mem_valid & mem_ready & (int_pend | any flag | mem_eret).
  - FLUSH: counts FLUSH_CYCLES; all MEM inputs ignored.
  - IDLE→FLUSH on commit; FLUSH→IDLE when flush_cnt reaches FLUSH_CYCLES-1.
- int_pend:
  - Set when int_response=1 in IDLE.
  - Cleared on a commit that takes the interrupt, or when int_response drops before being taken.
- Priority, highest first; excode in parentheses:
  - Int (0) via int_pend
  - AdEL fetch (4)
  - RI (10)
  - Ov (12)
  - Sys (8)
  - Bp (9)
  - AdEL data (4)
  - AdES (5)
  - eret, lowest.
- Commit cycle T: exc_valid=1 combinationally in T only.
  - Exception: exc_eret=0, exc_excode per priority, exc_bd=mem_bd, exc_epc = mem_bd ? mem_pc-4 : mem_pc (32-bit wrap).
  - exc_badvaddr = mem_pc for fetch AdEL; mem_daddr for data AdEL/AdES; 0 otherwise.
  - Eret only: exc_eret=1, exc_excode=0, exc_bd=0, exc_epc=0.
- Registered outputs, cycle T+1:
  - redirect_valid=1 for exactly one cycle.
  - redirect_pc = eret ? cp0_epc sampled at T : (status_bev ? VEC_BEV1 : VEC_BEV0).
  - flush=1 for cycles T+1..T+FLUSH_CYCLES.
- No new commit while in FLUSH, including simultaneous flags.
- Interrupt arriving during FLUSH sets int_pend only after return to IDLE.
- mem_valid=1 with mem_ready=0 holds; no commit until mem_ready=1.
- Reset mid-flush aborts immediately: flush and redirect_valid go 0.

Test Plan:
- Ov at mem_pc=0x8000_0010, bd=1, bev=1 -> exc_valid 1 cycle, excode=12, epc=0x8000_000C, bd=1; T+1 redirect_pc=0xBFC00380; flush high 2 cycles.
- Sys at pc=0x8000_0100, bd=0, bev=0 -> excode=8, epc=0x8000_0100; redirect 0x80000180.
- int_response=1 with RI set on the same instruction -> excode=0 (Int wins); int_pend clears after commit.
- Eret with cp0_epc=0x8000_2000 -> exc_valid=1, exc_eret=1; T+1 redirect_valid with redirect_pc=0x8000_2000.
- Data AdES mem_daddr=0x8000_0003, then Bp one cycle later during FLUSH -> one commit only, badvaddr=0x8000_0003, excode=5; Bp ignored.
- resetn low during the second flush cycle -> flush=0 asynchronously, FSM IDLE; next Bp after release commits normally with excode=9.

Source files
------------

// File: rtl/exc_commit_if.sv
// CP0 exception strobe bus: the commit unit drives it, CP0 consumes it.
interface exc_commit_if;
   logic        exc_valid;
   logic [4:0]  exc_excode;
   logic        exc_bd;
   logic [31:0] exc_epc;
   logic [31:0] exc_badvaddr;
   logic        exc_eret;

   modport master (output exc_valid, exc_excode, exc_bd, exc_epc, exc_badvaddr, exc_eret);
   modport slave  (input  exc_valid, exc_excode, exc_bd, exc_epc, exc_badvaddr, exc_eret);
endinterface

// File: rtl/exc_commit.sv
// MEM-stage exception commit: prioritises exceptions/eret, pulses CP0,
// then holds a flush window and issues a one-shot PC redirect.
module exc_commit #(
   parameter int          FLUSH_CYCLES = 2,
   parameter logic [31:0] VEC_BEV1     = 32'hBFC00380,
   parameter logic [31:0] VEC_BEV0     = 32'h80000180
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic        mem_ready,
   input  logic [31:0] mem_pc,
   input  logic        mem_bd,
   input  logic        mem_adel_if,
   input  logic        mem_ri,
   input  logic        mem_ov,
   input  logic        mem_sys,
   input  logic        mem_bp,
   input  logic        mem_adel,
   input  logic        mem_ades,
   input  logic        mem_eret,
   input  logic [31:0] mem_daddr,
   input  logic        int_response,
   input  logic [31:0] cp0_epc,
   input  logic        status_bev,
   exc_commit_if.master cp0,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);
   typedef enum logic {IDLE, FLUSH} state_t;

   localparam logic [2:0] LAST = 3'(FLUSH_CYCLES - 1);

   state_t      state;
   logic        int_pend;
   logic [2:0]  flush_cnt;
   logic        any_exc;
   logic        commit;
   logic [4:0]  excode;
   logic [31:0] badvaddr;

   always_comb begin
      excode   = 5'd0;
      badvaddr = 32'd0;
      any_exc  = 1'b1;
      if (int_pend)         excode = 5'd0;
      else if (mem_adel_if) begin excode = 5'd4; badvaddr = mem_pc; end
      else if (mem_ri)      excode = 5'd10;
      else if (mem_ov)      excode = 5'd12;
      else if (mem_sys)     excode = 5'd8;
      else if (mem_bp)      excode = 5'd9;
      else if (mem_adel)    begin excode = 5'd4; badvaddr = mem_daddr; end
      else if (mem_ades)    begin excode = 5'd5; badvaddr = mem_daddr; end
      else                  any_exc = 1'b0;
   end

   assign commit = (state == IDLE) & mem_valid & mem_ready & (any_exc | mem_eret);

   // Exception fields are forced to zero unless an exception actually commits,
   // so an eret-only commit reports all-zero cause fields.
   assign cp0.exc_valid    = commit;
   assign cp0.exc_eret     = commit & ~any_exc;
   assign cp0.exc_excode   = (commit & any_exc) ? excode : 5'd0;
   assign cp0.exc_bd       = commit & any_exc & mem_bd;
   assign cp0.exc_epc      = (commit & any_exc) ? (mem_bd ? mem_pc - 32'd4 : mem_pc) : 32'd0;
   assign cp0.exc_badvaddr = (commit & any_exc) ? badvaddr : 32'd0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state          <= IDLE;
         int_pend       <= 1'b0;
         flush_cnt      <= 3'd0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               int_pend <= (commit && int_pend) ? 1'b0 : int_response;
               if (commit) begin
                  state          <= FLUSH;
                  flush          <= 1'b1;
                  flush_cnt      <= 3'd0;
                  redirect_valid <= 1'b1;
                  redirect_pc    <= any_exc ? (status_bev ? VEC_BEV1 : VEC_BEV0) : cp0_epc;
               end
            end
            FLUSH: begin
               redirect_valid <= 1'b0;
               // A request that goes away while flushing is dropped; new ones wait for IDLE.
               if (!int_response) int_pend <= 1'b0;
               if (flush_cnt == LAST) begin
                  state <= IDLE;
                  flush <= 1'b0;
               end else begin
                  flush_cnt <= flush_cnt + 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_exc_commit.sv
// Randomised scoreboard bench for exc_commit with a table-driven priority model.
module tb_exc_commit;
   localparam int          FC   = 2;
   localparam logic [31:0] BEV1 = 32'hBFC00380;
   localparam logic [31:0] BEV0 = 32'h80000180;

   typedef struct {
      bit mv, mr, bd, adel_if, ri, ov, sys, bp, adel, ades, eret, intr, bev;
      logic [31:0] pc, daddr, epc;
   } stim_t;
   typedef struct {
      int cyc; logic [4:0] code; logic bd; logic [31:0] epc, bva; logic eret;
   } exc_t;
   typedef struct { int cyc; logic [31:0] pc; } red_t;

   logic        clk = 1'b0, resetn = 1'b0;
   logic        mem_valid, mem_ready, mem_bd, mem_adel_if, mem_ri, mem_ov, mem_sys;
   logic        mem_bp, mem_adel, mem_ades, mem_eret, int_response, status_bev;
   logic [31:0] mem_pc, mem_daddr, cp0_epc;
   logic        flush, redirect_valid;
   logic [31:0] redirect_pc;

   exc_commit_if cp0();

   exc_commit #(.FLUSH_CYCLES(FC), .VEC_BEV1(BEV1), .VEC_BEV0(BEV0)) dut (
      .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_pc(mem_pc), .mem_bd(mem_bd), .mem_adel_if(mem_adel_if), .mem_ri(mem_ri),
      .mem_ov(mem_ov), .mem_sys(mem_sys), .mem_bp(mem_bp), .mem_adel(mem_adel),
      .mem_ades(mem_ades), .mem_eret(mem_eret), .mem_daddr(mem_daddr),
      .int_response(int_response), .cp0_epc(cp0_epc), .status_bev(status_bev),
      .cp0(cp0), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   vectors = 0, errors = 0;
   exc_t exc_q[$];
   red_t red_q[$];
   bit   exp_flush[8192];
   bit   mon_on = 0;
   int   m_busy = 0;
   bit   m_ip = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Priority table: the first raised source wins.
   function automatic exc_t ref_exc(input stim_t s, input bit ip);
      bit   f[8];
      int   code[8];
      exc_t e;
      e = '{default: 0};
      f = '{ip, s.adel_if, s.ri, s.ov, s.sys, s.bp, s.adel, s.ades};
      code = '{0, 4, 10, 12, 8, 9, 4, 5};
      for (int i = 0; i < 8; i++) begin
         if (f[i]) begin
            e.code = 5'(code[i]);
            e.bd   = s.bd;
            e.epc  = s.bd ? s.pc - 32'd4 : s.pc;
            e.bva  = (i == 1) ? s.pc : (i >= 6) ? s.daddr : 32'd0;
            return e;
         end
      end
      e.eret = 1'b1;
      return e;
   endfunction

   function automatic stim_t idle_s();
      stim_t s;
      s = '{default: 0};
      return s;
   endfunction

   task automatic drive(input stim_t s);
      mem_valid = s.mv; mem_ready = s.mr; mem_pc = s.pc; mem_bd = s.bd;
      mem_adel_if = s.adel_if; mem_ri = s.ri; mem_ov = s.ov; mem_sys = s.sys;
      mem_bp = s.bp; mem_adel = s.adel; mem_ades = s.ades; mem_eret = s.eret;
      mem_daddr = s.daddr; int_response = s.intr; cp0_epc = s.epc; status_bev = s.bev;
   endtask

   task automatic apply(input stim_t s);
      bit   idle, anyf, commit;
      exc_t e;
      red_t r;
      @(posedge clk); #1;
      drive(s);
      idle   = (m_busy == 0);
      anyf   = s.adel_if | s.ri | s.ov | s.sys | s.bp | s.adel | s.ades;
      commit = idle && s.mv && s.mr && (m_ip || anyf || s.eret);
      if (commit) begin
         e = ref_exc(s, m_ip);
         e.cyc = cyc;
         exc_q.push_back(e);
         r.cyc = cyc + 1;
         r.pc  = e.eret ? s.epc : (s.bev ? BEV1 : BEV0);
         red_q.push_back(r);
         for (int k = 1; k <= FC; k++) exp_flush[cyc + k] = 1'b1;
      end
      if (idle) m_ip = (commit && m_ip) ? 1'b0 : s.intr;
      else      m_ip = m_ip && s.intr;
      if (commit) m_busy = FC;
      else if (m_busy > 0) m_busy--;
   endtask

   exc_t mon_e;
   red_t mon_r;
   always @(negedge clk) begin
      if (mon_on && resetn) begin
         if (cp0.exc_valid) begin
            if (exc_q.size() == 0) chk("exc_unexpected", 32'd1, 32'd0);
            else begin
               mon_e = exc_q.pop_front();
               chk("exc_cycle", cyc, mon_e.cyc);
               chk("exc_excode", 32'(cp0.exc_excode), 32'(mon_e.code));
               chk("exc_bd", 32'(cp0.exc_bd), 32'(mon_e.bd));
               chk("exc_epc", cp0.exc_epc, mon_e.epc);
               chk("exc_badvaddr", cp0.exc_badvaddr, mon_e.bva);
               chk("exc_eret", 32'(cp0.exc_eret), 32'(mon_e.eret));
            end
         end
         if (redirect_valid) begin
            if (red_q.size() == 0) chk("redirect_unexpected", 32'd1, 32'd0);
            else begin
               mon_r = red_q.pop_front();
               chk("redirect_cycle", cyc, mon_r.cyc);
               chk("redirect_pc", redirect_pc, mon_r.pc);
            end
         end
         chk("flush", 32'(flush), 32'(exp_flush[cyc]));
      end
   end

   stim_t s;
   initial begin
      drive(idle_s());
      repeat (3) @(posedge clk);
      #1;
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      chk("rst_exc_valid", 32'(cp0.exc_valid), 32'd0);
      chk("rst_exc_epc", cp0.exc_epc, 32'd0);
      #2 resetn = 1'b1;
      mon_on = 1'b1;

      // Ov in delay slot, BEV=1
      s = idle_s(); s.mv = 1; s.mr = 1; s.ov = 1; s.pc = 32'h8000_0010; s.bd = 1; s.bev = 1;
      apply(s); repeat (3) apply(idle_s());
      // Sys, BEV=0
      s = idle_s(); s.mv = 1; s.mr = 1; s.sys = 1; s.pc = 32'h8000_0100;
      apply(s); repeat (3) apply(idle_s());
      // Pending interrupt beats RI on the same instruction
      s = idle_s(); s.intr = 1; apply(s);
      s.mv = 1; s.mr = 1; s.ri = 1; s.pc = 32'h8000_0200; apply(s);
      repeat (4) apply(idle_s());
      // Eret returns to EPC
      s = idle_s(); s.mv = 1; s.mr = 1; s.eret = 1; s.epc = 32'h8000_2000; s.pc = 32'h8000_0300;
      apply(s); repeat (3) apply(idle_s());
      // AdES, then Bp during the flush window is ignored
      s = idle_s(); s.mv = 1; s.mr = 1; s.ades = 1; s.daddr = 32'h8000_0003; s.pc = 32'h8000_0400;
      apply(s);
      s = idle_s(); s.mv = 1; s.mr = 1; s.bp = 1; s.pc = 32'h8000_0404; apply(s);
      repeat (3) apply(idle_s());
      // Stall then complete
      s = idle_s(); s.mv = 1; s.mr = 0; s.ov = 1; s.pc = 32'h8000_0500;
      apply(s); apply(s); s.mr = 1; apply(s); repeat (3) apply(idle_s());
      // EPC wraps below zero
      s = idle_s(); s.mv = 1; s.mr = 1; s.adel_if = 1; s.pc = 32'h0000_0000; s.bd = 1;
      apply(s); repeat (3) apply(idle_s());
      // Reset during the second flush cycle aborts the window
      s = idle_s(); s.mv = 1; s.mr = 1; s.bp = 1; s.pc = 32'h8000_0600;
      apply(s); apply(idle_s());
      @(posedge clk); #1;
      drive(idle_s());
      #2 resetn = 1'b0;
      #1;
      chk("flush_async_reset", 32'(flush), 32'd0);
      chk("redirect_async_reset", 32'(redirect_valid), 32'd0);
      m_busy = 0; m_ip = 0;
      for (int k = 0; k < 8; k++) exp_flush[cyc + k] = 1'b0;
      @(posedge clk); #3 resetn = 1'b1;
      s = idle_s(); s.mv = 1; s.mr = 1; s.bp = 1; s.pc = 32'h8000_0700;
      apply(s); repeat (3) apply(idle_s());

      // Random traffic
      s = idle_s();
      for (int n = 0; n < 1500; n++) begin
         s.mv      = ($urandom_range(0, 3) != 0);
         s.mr      = ($urandom_range(0, 2) != 0);
         s.bd      = $urandom_range(0, 1) == 1;
         s.adel_if = ($urandom_range(0, 11) == 0);
         s.ri      = ($urandom_range(0, 11) == 0);
         s.ov      = ($urandom_range(0, 11) == 0);
         s.sys     = ($urandom_range(0, 11) == 0);
         s.bp      = ($urandom_range(0, 11) == 0);
         s.adel    = ($urandom_range(0, 11) == 0);
         s.ades    = ($urandom_range(0, 11) == 0);
         s.eret    = ($urandom_range(0, 7) == 0);
         s.bev     = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 11) == 0) s.intr = ~s.intr;
         s.pc      = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 3)) << 2 : $urandom & ~32'h3;
         s.daddr   = $urandom;
         s.epc     = $urandom;
         apply(s);
      end
      repeat (6) apply(idle_s());
      #1;
      chk("exc_queue_drained", exc_q.size(), 32'd0);
      chk("redirect_queue_drained", red_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
